// File: rtl/cdb_pkg.sv
// Types and widths shared by the functional units, the CDB queue and the reservation stations.
// Defines a CDB entry (tag + result) and the default field widths.
package cdb_pkg;

    localparam int CDB_TAG_W  = 7;
    localparam int CDB_DATA_W = 32;

    typedef struct packed {
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_broadcast_queue_rr_arbiter.sv
// Round-robin pick among NUM_FU requests, searching upward from rr_ptr and wrapping at NUM_FU.
// Combinational, so it adds no cycle of latency; grant is one-hot and grant_vld is low when nothing requests.
module rr_arbiter #(
    parameter int NUM_FU = 4,
    parameter int PW     = 2
) (
    input  logic [NUM_FU-1:0] req,
    input  logic [PW-1:0]     rr_ptr,
    output logic [NUM_FU-1:0] grant,
    output logic [PW-1:0]     grant_idx,
    output logic              grant_vld
);

    int cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = 0;
        for (int i = 0; i < NUM_FU; i++) begin
            cand = (int'(rr_ptr) + i) % NUM_FU;
            if (!grant_vld && req[cand]) begin
                grant_vld   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/cdb_broadcast_queue.sv
// Collects FU results, acknowledges each one with a single-cycle queued pulse, and broadcasts them on the CDB in FIFO order.
// A result appears on the CDB one cycle after done; while the FIFO is full, completed FUs remain pending and nothing is dropped.
module cdb_broadcast_queue
    import cdb_pkg::*;
#(
    parameter int NUM_FU     = 4,
    parameter int DATA_WIDTH = CDB_DATA_W,
    parameter int TAG_WIDTH  = CDB_TAG_W,
    parameter int DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_FU-1:0]            done_i,
    input  logic [NUM_FU*TAG_WIDTH-1:0]  tag_i,
    input  logic [NUM_FU*DATA_WIDTH-1:0] data_i,
    output logic [NUM_FU-1:0]            queued_o,
    output logic                         cdb_valid,
    output logic [TAG_WIDTH-1:0]         cdb_tag,
    output logic [DATA_WIDTH-1:0]        cdb_data,
    input  logic                         cdb_ready,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [NUM_FU-1:0] pending;
    logic [NUM_FU-1:0] req;
    logic [NUM_FU-1:0] grant;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     rr_next;
    logic [PW-1:0]     win_idx;
    logic              win_vld;
    logic              enq;
    logic              deq;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    entry_t            mem [DEPTH];
    entry_t            win_entry;
    entry_t            head;

    // A done pulse competes in the same cycle it arrives, which gives the single-cycle path to the CDB.
    assign req = pending | done_i;

    rr_arbiter #(
        .NUM_FU (NUM_FU),
        .PW     (PW)
    ) u_arb (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (win_idx),
        .grant_vld (win_vld)
    );

    assign deq     = cdb_valid & cdb_ready;
    // A full FIFO can still take an entry when its head leaves in the same cycle.
    assign enq     = win_vld & ((count_o != CW'(DEPTH)) | deq);
    assign rr_next = (win_idx == PW'(NUM_FU - 1)) ? '0 : win_idx + 1'b1;

    assign win_entry.tag  = tag_i[int'(win_idx)*TAG_WIDTH +: TAG_WIDTH];
    assign win_entry.data = data_i[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];

    assign head      = mem[rd_ptr];
    assign cdb_valid = (count_o != '0);
    assign cdb_tag   = cdb_valid ? head.tag  : '0;
    assign cdb_data  = cdb_valid ? head.data : '0;

    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= win_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending  <= '0;
            queued_o <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_o  <= '0;
            rr_ptr   <= '0;
        end else begin
            pending  <= req & ~(enq ? grant : '0);
            queued_o <= enq ? grant : '0;
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= rr_next;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count_o <= count_o + 1'b1;
                2'b01:   count_o <= count_o - 1'b1;
                default: count_o <= count_o;
            endcase
        end
    end

endmodule

// File: doc/cdb_broadcast_queue.md
Name: cdb_broadcast_queue

Overview:
- Sits directly downstream of the execution functional units (FU_ADD and peers).
- Captures each FU's completed result and tag, and returns a one-cycle `queued` pulse so the FU can go idle.
- Buffers results in a FIFO and drives the common data bus (CDB) with one {tag, data} per cycle to the reservation stations and ROB.

Parameters:
- NUM_FU, 4, number of functional-unit input ports.
- DATA_WIDTH, 32, result width.
- TAG_WIDTH, 7, execution tag width.
- DEPTH, 8, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-low (0 = reset).
- done_i  input  NUM_FU  per-FU completion pulse (one cycle).
- tag_i  input  NUM_FU*TAG_WIDTH  per-FU executionTag_out; FU i occupies slice i.
- data_i  input  NUM_FU*DATA_WIDTH  per-FU result; FU i occupies slice i.
- queued_o  output  NUM_FU  per-FU one-cycle acknowledge; drives the FU `queued` input.
- cdb_valid  output  1  head entry valid on the CDB.
- cdb_tag  output  TAG_WIDTH  head entry tag.
- cdb_data  output  DATA_WIDTH  head entry result.
- cdb_ready  input  1  consumer accepts the head this cycle.
- count_o  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst==0 at posedge) clears:
  - pending[], queued_o, FIFO pointers, count_o, the round-robin pointer;
  - cdb_valid=0, cdb_tag=0, cdb_data=0.
  - Reset mid-operation discards all pending and buffered results. No queued_o is issued for them.
- Pending latch, per FU i:
  - pending[i] is set at the posedge where done_i[i]=1.
  - pending[i] is cleared at the posedge where FU i is written into the FIFO.
  - While FU i is pending or acknowledged, tag_i/data_i slice i is stable: the FU holds its operands until idle.
- Request: req[i] = pending[i] | done_i[i].
  - done_i[i] while pending[i]=1 is a protocol error. It is ignored functionally and flagged by a bench assertion.
- Enqueue, at most one per cycle:
  - Allowed when count_o < DEPTH, or when count_o == DEPTH and a dequeue occurs in the same cycle (cdb_valid & cdb_ready).
  - Winner: the first set req[] bit scanning from rr_ptr upward, modulo NUM_FU.
  - On enqueue: write {tag_i, data_i} of the winner at wr_ptr, wr_ptr+1 (wraps at DEPTH), rr_ptr <= winner+1 mod NUM_FU, clear pending[winner].
  - No enqueue leaves rr_ptr unchanged.
- queued_o: registered. Enqueue of FU i at posedge T gives queued_o[i]=1 for exactly the cycle after T. At most one bit is set.
- Dequeue: when cdb_valid & cdb_ready, rd_ptr+1 (wraps).
- Count update: count_o +1 on enqueue only, -1 on dequeue only, unchanged on both.
- CDB outputs:
  - cdb_valid = (count_o != 0).
  - cdb_tag/cdb_data = entry at rd_ptr; they hold while cdb_ready=0.
- Latency: done_i at cycle T with empty FIFO and no contention gives cdb_valid with that result in cycle T+1; queued_o also in T+1.
- Ordering: FIFO order equals enqueue order. No bypass around the FIFO.
- Full with cdb_ready=0: requests stay pending indefinitely with no loss. Round-robin guarantees each pending FU is served within NUM_FU enqueues.
- Overflow and underflow are impossible by construction; the bench asserts count_o <= DEPTH.

Decomposition:
- Shared package (cdb_pkg):
  - cdb_entry_t struct {tag, data};
  - TAG_WIDTH / DATA_WIDTH defaults, shared with the FUs and reservation stations.
- Sub-module rr_arbiter (NUM_FU requests, rr_ptr input, one-hot grant + index output, combinational).
- FIFO storage, pending latch and queued_o generation stay in the top module.

Test Plan:
- Single result: done_i=4'b0001, tag 7'h05, data 32'h0000_0010 in cycle 0 -> cycle 1: queued_o=4'b0001, cdb_valid=1, cdb_tag=5, cdb_data=0x10; cdb_ready=1 -> cycle 2: cdb_valid=0.
- Simultaneous completion: done_i=4'b1111 at cycle 0 (tags 1,2,3,4), rr_ptr=0, cdb_ready=1:
  - queued_o one-hot 0001, 0010, 0100, 1000 in cycles 1-4;
  - CDB tags 1,2,3,4 in cycles 1-4.
- Fill and backpressure: cdb_ready=0; 9 completions on FU0..FU3, re-issued as each is acknowledged:
  - count_o saturates at 8; the 9th stays pending with no queued_o;
  - raise cdb_ready -> 9th enqueued in the same cycle as the first dequeue; count_o stays 8 that cycle; the 9th result appears 9th on the CDB.
- Fairness: FU0 completes every cycle right after each ack, FU2 completes once at cycle 0, FIFO near full -> FU2 acknowledged within 4 enqueues.
- Wrap-around: 20 sequential results through DEPTH=8 with cdb_ready toggling 1,0,1,0 -> all 20 tags appear in order, none duplicated or lost.
- Reset mid-operation: 3 entries buffered and FU1 pending, rst=0 for one cycle -> next cycle: cdb_valid=0, count_o=0, queued_o=0; a later FU1 done is accepted normally.
